// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, funct fields, ALU codes,
// writeback selects, FSM states and the opcode classifier used at DECODE.
package mc_sequencer_pkg;

  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_COND  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  localparam logic [2:0] ALU_add = 3'd0;
  localparam logic [2:0] ALU_sub = 3'd1;
  localparam logic [2:0] ALU_and = 3'd2;
  localparam logic [2:0] ALU_or  = 3'd3;
  localparam logic [2:0] ALU_xor = 3'd4;
  localparam logic [2:0] ALU_slt = 3'd5;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  typedef enum logic [2:0] {
    CL_ARITH, CL_ADDI, CL_LOAD, CL_STORE, CL_COND, CL_JAL, CL_JALR, CL_OTHER
  } op_class_e;

  function automatic op_class_e op_class(input logic [6:0] opcode);
    case (opcode)
      OP_ARITH: return CL_ARITH;
      OP_ADDI:  return CL_ADDI;
      OP_LOAD:  return CL_LOAD;
      OP_STORE: return CL_STORE;
      OP_COND:  return CL_COND;
      OP_JAL:   return CL_JAL;
      OP_JALR:  return CL_JALR;
      default:  return CL_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_alu_op_decode.sv
// Register-register ALU operation decode from funct3/funct7.
module mc_sequencer_alu_op_decode (
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_op
);
  import mc_sequencer_pkg::*;

  always_comb begin
    alu_op = ALU_add;
    case (funct3)
      F3_ADD_SUB: alu_op = (funct7 == F7_SUB) ? ALU_sub : ALU_add;
      F3_AND:     alu_op = ALU_and;
      F3_OR:      alu_op = ALU_or;
      F3_XOR:     alu_op = ALU_xor;
      F3_SLT:     alu_op = ALU_slt;
      default:    alu_op = ALU_add;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retired-instruction counter.
// Build option MC_ILLEGAL_TRAP_EN: unknown opcodes halt with a sticky illegal flag.
module mc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             ALUsrc,
  output logic [2:0]       ALUOp,
  output logic [1:0]       memtoreg,
  output logic             reg_wr,
  output logic             bra,
  output logic             bne,
  output logic             jump,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);
  import mc_sequencer_pkg::*;

  logic [2:0]       state_q, state_d;
  op_class_e        class_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q;
  logic [2:0]       arith_op;
  logic             retire;
  logic [CNT_W-1:0] instret_q;
  logic             unused_instr;

  // Register indices and immediates belong to the datapath.
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  mc_sequencer_alu_op_decode u_alu_op_decode (
    .funct3 (funct3_q),
    .funct7 (funct7_q),
    .alu_op (arith_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      class_q  <= CL_OTHER;
      funct3_q <= '0;
      funct7_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        class_q  <= op_class(instr[6:0]);
        funct3_q <= instr[14:12];
        funct7_q <= instr[31:25];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    ALUsrc   = 1'b0;
    ALUOp    = ALU_add;
    memtoreg = M2R_ALU;
    reg_wr   = 1'b0;
    bra      = 1'b0;
    bne      = 1'b0;
    jump     = 1'b0;
    retire   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_class(instr[6:0]) != CL_OTHER) begin
          state_d = EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          retire  = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      EXEC: begin
        unique case (class_q)
          CL_ARITH: begin
            ALUOp   = arith_op;
            state_d = WB;
          end
          CL_ADDI: begin
            ALUsrc  = 1'b1;
            state_d = WB;
          end
          CL_LOAD, CL_STORE: begin
            ALUsrc  = 1'b1;
            state_d = MEM;
          end
          CL_COND: begin
            ALUOp   = ALU_sub;
            bra     = 1'b1;
            bne     = (funct3_q == F3_BNE);
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_JAL: begin
            jump    = 1'b1;
            pc_wr   = 1'b1;
            state_d = WB;
          end
          CL_JALR: begin
            ALUsrc  = 1'b1;
            jump    = 1'b1;
            pc_wr   = 1'b1;
            state_d = WB;
          end
          CL_OTHER: state_d = FETCH;
        endcase
      end
      MEM: begin
        // Address computation stays on the ALU for the whole access.
        mem_req = 1'b1;
        iord    = 1'b1;
        ALUsrc  = 1'b1;
        mem_we  = (class_q == CL_STORE);
        if (mem_ack) begin
          if (class_q == CL_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_wr   = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
        if (class_q == CL_LOAD) begin
          memtoreg = M2R_MEM;
        end else if (class_q == CL_JAL || class_q == CL_JALR) begin
          memtoreg = M2R_PC4;
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    // Reset silences every output immediately, including a pending Mealy ack path.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      ALUsrc   = 1'b0;
      ALUOp    = ALU_add;
      memtoreg = M2R_ALU;
      reg_wr   = 1'b0;
      bra      = 1'b0;
      bne      = 1'b0;
      jump     = 1'b0;
      retire   = 1'b0;
    end
  end

  assign instr_done = retire;
  assign instret    = instret_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = (state_q == HALT) && !rst;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: vector table, hand-written corner cases and
// randomized instructions against a phase-level reference model.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_wr, pc_wr, ALUsrc, reg_wr, bra, bne, jump;
  logic        instr_done, illegal;
  logic [2:0]  ALUOp;
  logic [1:0]  memtoreg;
  logic [3:0]  instret;

  mc_sequencer #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .ALUsrc     (ALUsrc),
    .ALUOp      (ALUOp),
    .memtoreg   (memtoreg),
    .reg_wr     (reg_wr),
    .bra        (bra),
    .bne        (bne),
    .jump       (jump),
    .instr_done (instr_done),
    .instret    (instret),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] outv;
  assign outv = {mem_req, mem_we, iord, ir_wr, pc_wr, ALUsrc, ALUOp, memtoreg,
                 reg_wr, bra, bne, jump, instr_done, illegal};

  int          n_checks = 0;
  int          n_errors = 0;
  int          model_cnt = 0;
  bit          noise_en = 1'b0;
  logic [16:0] trace [16];
  int          trace_len;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    int          len;
    logic [16:0] ex;
    logic [16:0] last;
  } tv_t;
  tv_t tv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] v(input bit req, input bit we, input bit io, input bit irw,
                                    input bit pcw, input bit src, input logic [2:0] op,
                                    input logic [1:0] m2r, input bit rw, input bit br,
                                    input bit bn, input bit jp, input bit dn);
    return {req, we, io, irw, pcw, src, op, m2r, rw, br, bn, jp, dn, 1'b0};
  endfunction

  function automatic logic noise();
    return noise_en ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  // One clock cycle: drive ack, sample mid-cycle, compare, then move past the next edge.
  task automatic step(input logic ack, input logic [16:0] expv, input string name);
    mem_ack = ack;
    @(negedge clk);
    chk(name, 32'(outv), 32'(expv));
    chk({name, "/instret"}, 32'(instret), 32'(model_cnt % 16));
    if (trace_len < 16) trace[trace_len] = outv;
    trace_len++;
    if (expv[1]) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Reference: expected phase sequence of one instruction from its opcode class.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [2:0] aop;
    logic [1:0] m2r;
    bit is_ar, is_ai, is_ld, is_st, is_br, is_jal, is_jalr;
    opc     = ins[6:0];
    f3      = ins[14:12];
    is_ar   = (opc == 7'h33);
    is_ai   = (opc == 7'h13);
    is_ld   = (opc == 7'h03);
    is_st   = (opc == 7'h23);
    is_br   = (opc == 7'h63);
    is_jal  = (opc == 7'h6F);
    is_jalr = (opc == 7'h67);
    case (f3)
      3'b000:  aop = (ins[31:25] == 7'b0100000) ? 3'd1 : 3'd0;
      3'b111:  aop = 3'd2;
      3'b110:  aop = 3'd3;
      3'b100:  aop = 3'd4;
      3'b010:  aop = 3'd5;
      default: aop = 3'd0;
    endcase
    trace_len = 0;
    instr = ins;
    for (int i = 0; i < fw; i++) step(1'b0, v(1,0,0,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
    step(1'b1, v(1,0,0,1,1,0,0,0,0,0,0,0,0), "fetch_ack");
    if (!(is_ar || is_ai || is_ld || is_st || is_br || is_jal || is_jalr)) begin
      step(noise(), v(0,0,0,0,0,0,0,0,0,0,0,0,1), "decode_nop");
      return;
    end
    step(noise(), 17'h0, "decode");
    if (is_br) begin
      step(noise(), v(0,0,0,0,0,0,3'd1,0,0,1,(f3 == 3'b001),0,1), "exec_branch");
      return;
    end
    if (is_ar)        step(noise(), v(0,0,0,0,0,0,aop,0,0,0,0,0,0), "exec_arith");
    else if (is_jal)  step(noise(), v(0,0,0,0,1,0,0,0,0,0,0,1,0), "exec_jal");
    else if (is_jalr) step(noise(), v(0,0,0,0,1,1,0,0,0,0,0,1,0), "exec_jalr");
    else              step(noise(), v(0,0,0,0,0,1,0,0,0,0,0,0,0), "exec_imm");
    if (is_ld || is_st) begin
      for (int i = 0; i < mw; i++) step(1'b0, v(1,is_st,1,0,0,1,0,0,0,0,0,0,0), "mem_wait");
      step(1'b1, v(1,is_st,1,0,0,1,0,0,0,0,0,0,is_st), "mem_ack");
      if (is_st) return;
    end
    m2r = is_ld ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
    step(noise(), v(0,0,0,0,0,0,0,m2r,1,0,0,0,1), "writeback");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dut_len;
    logic [31:0] r;
    logic [6:0] unk [4];
    unk = '{7'h7F, 7'h37, 7'h17, 7'h0F};

    tv[0]  = '{32'h002081B3, 0, 0, 4, 17'h00000, 17'h00022};  // ADD
    tv[1]  = '{32'h402081B3, 0, 0, 4, 17'h00100, 17'h00022};  // SUB
    tv[2]  = '{32'h0020C1B3, 1, 0, 5, 17'h00400, 17'h00022};  // XOR
    tv[3]  = '{32'h0020F1B3, 0, 0, 4, 17'h00200, 17'h00022};  // AND
    tv[4]  = '{32'h0020E1B3, 0, 0, 4, 17'h00300, 17'h00022};  // OR
    tv[5]  = '{32'h0020A1B3, 0, 0, 4, 17'h00500, 17'h00022};  // SLT
    tv[6]  = '{32'h002091B3, 0, 0, 4, 17'h00000, 17'h00022};  // unlisted funct3
    tv[7]  = '{32'h00508093, 2, 0, 6, 17'h00800, 17'h00022};  // ADDI
    tv[8]  = '{32'h00802283, 0, 3, 8, 17'h00800, 17'h00062};  // LW
    tv[9]  = '{32'h0020A423, 1, 2, 7, 17'h00800, 17'h1C802};  // SW
    tv[10] = '{32'h00209463, 0, 0, 3, 17'h0011A, 17'h0011A};  // BNE
    tv[11] = '{32'h00208463, 0, 0, 3, 17'h00112, 17'h00112};  // BEQ
    tv[12] = '{32'h008000EF, 0, 0, 4, 17'h01004, 17'h000A2};  // JAL
    tv[13] = '{32'h000080E7, 0, 0, 4, 17'h01804, 17'h000A2};  // JALR

    // Reset with a stray ack held high.
    rst = 1'b1;
    mem_ack = 1'b1;
    instr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(outv), 32'h0);
    chk("reset_instret", 32'(instret), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 0;

    for (int t = 0; t < 14; t++) begin
      run_instr(tv[t].ins, tv[t].fw, tv[t].mw);
      dut_len = 0;
      for (int k = 0; k < trace_len && k < 16; k++)
        if (trace[k][1] && dut_len == 0) dut_len = k + 1;
      chk($sformatf("vec%0d_latency", t), 32'(dut_len), 32'(tv[t].len));
      chk($sformatf("vec%0d_exec", t), 32'(trace[tv[t].fw + 2]), 32'(tv[t].ex));
      chk($sformatf("vec%0d_retire", t), dut_len > 0 ? 32'(trace[dut_len - 1]) : 32'hx,
          32'(tv[t].last));
    end

`ifdef MC_ILLEGAL_TRAP_EN
    instr = 32'h0000007F;
    trace_len = 0;
    step(1'b1, v(1,0,0,1,1,0,0,0,0,0,0,0,0), "ill_fetch");
    step(1'b0, 17'h0, "ill_decode");
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom_range(1));
      @(negedge clk);
      chk("halt_outputs", 32'(outv), 32'h1);
      chk("halt_instret", 32'(instret), 32'(model_cnt % 16));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("halt_reset_clears", 32'(outv), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    model_cnt = 0;
`else
    run_instr(32'h0000007F, 1, 0);
    chk("nop_length", 32'(trace_len), 32'd3);
    chk("nop_decode_retire", 32'(trace[2]), 32'h00002);
`endif
    run_instr(32'h002081B3, 0, 0);

    // Randomized instruction stream with spurious acks outside memory phases.
    noise_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      r = $urandom;
      case (sel)
        0: begin r[6:0] = 7'h33; r[31:25] = $urandom_range(1) ? 7'h20 : 7'h00; end
        1: r[6:0] = 7'h13;
        2: r[6:0] = 7'h03;
        3: r[6:0] = 7'h23;
        4: begin r[6:0] = 7'h63; r[14:12] = {2'b00, 1'($urandom_range(1))}; end
        5: r[6:0] = 7'h6F;
        6: r[6:0] = 7'h67;
        7: r[6:0] = 7'h33;
`ifdef MC_ILLEGAL_TRAP_EN
        default: r[6:0] = 7'h13;
`else
        default: r[6:0] = unk[$urandom_range(0, 3)];
`endif
      endcase
      run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    noise_en = 1'b0;

    // Reset lands in the SW data phase together with its ack.
    instr = 32'h0020A423;
    trace_len = 0;
    step(1'b1, v(1,0,0,1,1,0,0,0,0,0,0,0,0), "sw_fetch");
    step(1'b0, 17'h0, "sw_decode");
    step(1'b0, v(0,0,0,0,0,1,0,0,0,0,0,0,0), "sw_exec");
    mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mem_outputs", 32'(outv), 32'h0);
    chk("rst_mem_instret", 32'(instret), 32'h0);
    @(negedge clk);
    chk("rst_mem_outputs_hold", 32'(outv), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 0;
    step(1'b0, v(1,0,0,0,0,0,0,0,0,0,0,0,0), "restart_fetch");
    run_instr(32'h002081B3, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
